stage_4_carry_resolve: RTL and testbench
========================================

Name: stage_4_carry_resolve

Overview:
- Pipeline stage directly downstream of the normalization stage (stage 3) in the AV1 arithmetic encoder.
- Stage 3 emits up to two pre-carry output words per symbol. Each word is 9 bits; bit 8 is a carry into previously emitted bytes.
- This block resolves carries online by holding one pending byte and a run of 0xFF bytes, then streams final bitstream bytes one per cycle over a valid/ready handshake.
- A flush request drains all held state at end of frame.

Parameters:
- RUN_WIDTH, 16, width of the 0xFF-run counter (max run 2^RUN_WIDTH-1).
- D_SIZE, 4, width of in_num field (matches stage 3 count width; only values 0..2 legal).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  stage 3 has a word group
- in_ready  out  1  block accepts a group this cycle
- in_num  in  D_SIZE  number of words in group (0,1,2)
- in_word_0  in  9  first pre-carry word (processed first)
- in_word_1  in  9  second pre-carry word
- flush  in  1  end-of-stream drain request; sampled only when in_ready=1
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts out_byte
- out_byte  out  8  resolved bitstream byte
- done  out  1  one-cycle pulse after flush drain completes
- err  out  1  sticky: carry with no pending byte, or run counter overflow

Behaviour:
- Reset (async, immediate): state=S_IDLE, pending_valid=0, pending=0, run_cnt=0, out_valid=0, out_byte=0, done=0, err=0, in_ready=1 (combinational from S_IDLE).
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_byte and out_valid stay stable while out_valid && !out_ready.
- in_ready=1 only in S_IDLE.
- If flush and in_valid are high together, the input group is taken first and flush is ignored that cycle.
- Word rules for a 9-bit word w, with state pending/run_cnt:
  - w[8]=1 (carry): emit pending+1 (mod 256), then run_cnt bytes of 0x00; pending=w[7:0]; run_cnt=0. If !pending_valid: set err, drop the carry, pending=w[7:0].
  - w==0x0FF: if pending_valid, run_cnt++; else pending=0xFF, pending_valid=1. If run_cnt would exceed its max: set err, saturate.
  - w<0x0FF: if pending_valid, emit pending then run_cnt bytes of 0xFF; pending=w[7:0]; pending_valid=1; run_cnt=0.
- FSM states:
  - S_IDLE: accept a group. in_num=0 leaves state unchanged. Otherwise latch both words and go to S_WORD0.
  - S_WORD0: apply the rule to word0. If bytes are to be emitted, go to S_EMIT_PEND. Else go to S_WORD1 if in_num=2, else S_IDLE.
  - S_EMIT_PEND: present the pending byte (carry-adjusted); on transfer go to S_EMIT_RUN.
  - S_EMIT_RUN: present the fill byte (0x00 or 0xFF); decrement the run copy on each transfer. When zero, go to S_WORD1 if word1 is still unprocessed, else S_IDLE.
  - S_WORD1: same as S_WORD0 for word1; return to S_IDLE.
  - S_FLUSH: entered from S_IDLE on flush. Emits pending (if valid), then run_cnt×0xFF. Then pulses done for one cycle, clears pending_valid and run_cnt, returns to S_IDLE. err is not cleared.
- Latency: with out_ready=1, the first emitted byte is valid 2 cycles after input acceptance (S_WORD0 decode, then register). Afterwards 1 byte/cycle.
- Fill byte and run copy are latched at S_WORD entry. A new word's run updates take effect only after emission completes.
- Reset mid-drain discards all pending bytes. No partial byte is emitted.

Decomposition:
- Shared package pipeline_pkg:
  - state enum (S_IDLE, S_WORD0, S_WORD1, S_EMIT_PEND, S_EMIT_RUN, S_FLUSH)
  - constants BYTE_FF=8'hFF and CARRY_BIT=8
  - function classify_word returning {carry, is_ff, plain}
- One sub-module is natural: stage_4_out_reg, a single-entry output holding register implementing the stable-while-stalled rule.

Test Plan:
- Words 0x12, 0x34, flush (in_num=1 each) -> out bytes 0x12, 0x34; done pulses once; err=0.
- Words 0x12, 0xFF, 0xFF, 0x105, flush -> out 0x13, 0x00, 0x00, 0x05.
- Words 0x12, 0xFF, 0x40, flush -> out 0x12, 0xFF, 0x40.
- Single group in_num=2 {0x7F, 0x180}, then 0x01, flush -> out 0x80, 0x80, 0x01.
- Scenario 2 with out_ready toggling 1010… -> identical byte sequence; out_byte is held stable during each stall; in_ready stays 0 until drained.
- First word 0x101 after reset -> err=1 sticky, pending=0x01. Assert reset during an S_EMIT_RUN of 3 bytes -> out_valid drops immediately, and the next flush emits nothing except the done pulse.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the arithmetic-encoder back-end pipeline stages.
// Word classification splits a 9-bit pre-carry word into carry / 0xFF / plain.
package pipeline_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WORD0,
    S_WORD1,
    S_EMIT_PEND,
    S_EMIT_RUN,
    S_FLUSH
  } state_t;

  localparam logic [7:0] BYTE_FF   = 8'hFF;
  localparam int         CARRY_BIT = 8;

  typedef struct packed {
    logic carry;
    logic is_ff;
    logic plain;
  } word_class_t;

  function automatic word_class_t classify_word(input logic [8:0] w);
    word_class_t c;
    c.carry = w[CARRY_BIT];
    c.is_ff = !w[CARRY_BIT] && (w[7:0] == BYTE_FF);
    c.plain = !w[CARRY_BIT] && (w[7:0] != BYTE_FF);
    return c;
  endfunction

endpackage

// File: rtl/stage_4_carry_resolve_if.sv
// Bus between stage 3, the carry-resolve stage and the bitstream sink.
// Valid/ready: a transfer happens on any edge where valid && ready; out_byte is held while out_valid && !out_ready.
interface stage_4_carry_resolve_if #(
  parameter int D_SIZE = 4
);
  import pipeline_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [D_SIZE-1:0] in_num;
  logic [8:0]        in_word_0;
  logic [8:0]        in_word_1;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              done;
  logic              err;
  state_t            dbg_state;

  modport master (
    output in_valid, in_num, in_word_0, in_word_1, flush, out_ready,
    input  in_ready, out_valid, out_byte, done, err, dbg_state
  );

  modport slave (
    input  in_valid, in_num, in_word_0, in_word_1, flush, out_ready,
    output in_ready, out_valid, out_byte, done, err, dbg_state
  );

endinterface

// File: rtl/stage_4_out_reg.sv
// Single-entry output holding register: a new byte is taken only when the
// register is empty or its current byte transfers, so a stalled byte never changes.
module stage_4_out_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_byte
);

  logic take;
  assign take = load && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
    end else if (take) begin
      out_valid <= 1'b1;
      out_byte  <= load_byte;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stage_4_carry_resolve.sv
// Online carry resolution: holds one pending byte plus a run of 0xFF bytes and
// streams final bitstream bytes, one per cycle, once a later word settles them.
module stage_4_carry_resolve
  import pipeline_pkg::*;
#(
  parameter int RUN_WIDTH = 16,
  parameter int D_SIZE    = 4
) (
  input logic clk,
  input logic reset,
  stage_4_carry_resolve_if.slave bus
);

  localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;

  state_t                state, state_nx, ret_state, ret_nx, next_after;
  logic [7:0]            pending, pending_nx;
  logic                  pending_valid, pv_nx;
  logic [RUN_WIDTH-1:0]  run_cnt, run_nx;
  logic [RUN_WIDTH-1:0]  em_cnt, em_cnt_nx;
  logic [7:0]            em_fill, em_fill_nx;
  logic [8:0]            word0, word0_nx, word1, word1_nx, cur_word;
  logic                  num2, num2_nx;
  logic                  err_q, err_nx, done_q, done_nx;
  logic                  load, xfer, out_valid_q;
  logic [7:0]            load_byte, out_byte_q;
  word_class_t           cls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ret_state     <= S_IDLE;
      pending       <= 8'h00;
      pending_valid <= 1'b0;
      run_cnt       <= '0;
      em_cnt        <= '0;
      em_fill       <= 8'h00;
      word0         <= 9'h000;
      word1         <= 9'h000;
      num2          <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      ret_state     <= ret_nx;
      pending       <= pending_nx;
      pending_valid <= pv_nx;
      run_cnt       <= run_nx;
      em_cnt        <= em_cnt_nx;
      em_fill       <= em_fill_nx;
      word0         <= word0_nx;
      word1         <= word1_nx;
      num2          <= num2_nx;
      err_q         <= err_nx;
      done_q        <= done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ret_nx      = ret_state;
    pending_nx  = pending;
    pv_nx       = pending_valid;
    run_nx      = run_cnt;
    em_cnt_nx   = em_cnt;
    em_fill_nx  = em_fill;
    word0_nx    = word0;
    word1_nx    = word1;
    num2_nx     = num2;
    err_nx      = err_q;
    done_nx     = 1'b0;
    load        = 1'b0;
    load_byte   = pending;
    bus.in_ready = 1'b0;
    xfer        = out_valid_q && bus.out_ready;
    cur_word    = (state == S_WORD1) ? word1 : word0;
    cls         = classify_word(cur_word);
    next_after  = (state == S_WORD0 && num2) ? S_WORD1 : S_IDLE;

    unique case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_num != '0) begin
            word0_nx = bus.in_word_0;
            word1_nx = bus.in_word_1;
            num2_nx  = (bus.in_num == D_SIZE'(2));
            state_nx = S_WORD0;
          end
        end else if (bus.flush) begin
          state_nx = S_FLUSH;
        end
      end
      S_WORD0, S_WORD1: begin
        state_nx = next_after;
        if (cls.carry) begin
          // A carry settles pending+1 and turns the held 0xFF run into 0x00 bytes.
          if (pending_valid) begin
            load       = 1'b1;
            load_byte  = pending + 8'd1;
            em_cnt_nx  = run_cnt;
            em_fill_nx = 8'h00;
            ret_nx     = next_after;
            state_nx   = S_EMIT_PEND;
          end else begin
            err_nx = 1'b1;
          end
          pending_nx = cur_word[7:0];
          pv_nx      = 1'b1;
          run_nx     = '0;
        end else if (cls.is_ff) begin
          if (pending_valid) begin
            if (run_cnt == RUN_MAX) err_nx = 1'b1;
            else                    run_nx = run_cnt + RUN_WIDTH'(1);
          end else begin
            pending_nx = BYTE_FF;
            pv_nx      = 1'b1;
          end
        end else if (cls.plain) begin
          if (pending_valid) begin
            load       = 1'b1;
            load_byte  = pending;
            em_cnt_nx  = run_cnt;
            em_fill_nx = BYTE_FF;
            ret_nx     = next_after;
            state_nx   = S_EMIT_PEND;
          end
          pending_nx = cur_word[7:0];
          pv_nx      = 1'b1;
          run_nx     = '0;
        end
      end
      S_EMIT_PEND, S_EMIT_RUN: begin
        if (xfer) begin
          if (em_cnt != '0) begin
            load      = 1'b1;
            load_byte = em_fill;
            em_cnt_nx = em_cnt - RUN_WIDTH'(1);
            state_nx  = S_EMIT_RUN;
          end else begin
            state_nx = ret_state;
          end
        end
      end
      S_FLUSH: begin
        // Emission returns here with pending cleared, which then raises done.
        if (pending_valid) begin
          load       = 1'b1;
          load_byte  = pending;
          em_cnt_nx  = run_cnt;
          em_fill_nx = BYTE_FF;
          ret_nx     = S_FLUSH;
          pv_nx      = 1'b0;
          run_nx     = '0;
          state_nx   = S_EMIT_PEND;
        end else begin
          done_nx  = 1'b1;
          run_nx   = '0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  stage_4_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_byte (load_byte),
    .out_ready (bus.out_ready),
    .out_valid (out_valid_q),
    .out_byte  (out_byte_q)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_stage_4_carry_resolve.sv
// Bench for stage_4_carry_resolve: tail-of-stream arithmetic model plus
// hand-written byte lists for each directed scenario.
module tb_stage_4_carry_resolve;
  import pipeline_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stage_4_carry_resolve_if #(.D_SIZE(4)) bus ();

  stage_4_carry_resolve #(.RUN_WIDTH(16), .D_SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] hold[$];
  bit         m_err = 1'b0;
  int         done_exp = 0;
  int         done_seen = 0;
  int         ready_mode = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- model: unresolved tail as a big-endian number ----------------
  task automatic release_hold();
    foreach (hold[k]) exp_q.push_back(hold[k]);
    hold.delete();
  endtask

  task automatic model_word(input logic [8:0] w);
    bit c;
    if (w[8]) begin
      if (hold.size() == 0) begin
        m_err = 1'b1;
      end else begin
        c = 1'b1;
        for (int i = hold.size() - 1; i >= 0 && c; i--) begin
          if (hold[i] == 8'hFF) hold[i] = 8'h00;
          else begin
            hold[i] = hold[i] + 8'd1;
            c = 1'b0;
          end
        end
        release_hold();
      end
      hold.delete();
      hold.push_back(w[7:0]);
    end else if (w[7:0] == 8'hFF) begin
      hold.push_back(8'hFF);
    end else begin
      release_hold();
      hold.push_back(w[7:0]);
    end
  endtask

  // ---------------- output sink pacing ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = !bus.out_ready;
      default: bus.out_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_byte", 32'(bus.out_byte), 32'(prev_byte));
      end
      if (bus.out_valid) check("in_ready_busy", 32'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        check("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("out_byte", 32'(bus.out_byte), 32'(exp_q.pop_front()));
        got_q.push_back(bus.out_byte);
      end
      if (bus.done) done_seen++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_byte  = bus.out_byte;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_group(input logic [3:0] num, input logic [8:0] w0, input logic [8:0] w1, input bit fl);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 1);
    if (!bus.in_ready) return;
    bus.in_valid  = 1'b1;
    bus.in_num    = num;
    bus.in_word_0 = w0;
    bus.in_word_1 = w1;
    bus.flush     = fl;
    if (num != 4'd0) begin
      model_word(w0);
      if (num == 4'd2) model_word(w1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic send(input logic [8:0] w);
    send_group(4'd1, w, 9'h000, 1'b0);
  endtask

  task automatic do_flush();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    bus.flush = 1'b1;
    release_hold();
    done_exp++;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    guard = 0;
    while (done_seen != done_exp && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("done_count", 32'(done_seen), 32'(done_exp));
  endtask

  task automatic end_scenario(input string name, input int n, input logic [63:0] lit);
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && bus.dbg_state == S_IDLE && !bus.out_valid) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_exp_left"}, 32'(exp_q.size()), 0);
    check({name, "_len"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({name, "_lit"}, 32'(got_q[i]), 32'(lit[63-8*i -: 8]));
    check({name, "_err"}, 32'(bus.err), 32'(m_err));
    got_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int guard;
    bus.in_valid  = 1'b0;
    bus.in_num    = 4'd0;
    bus.in_word_0 = 9'h000;
    bus.in_word_1 = 9'h000;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_byte", 32'(bus.out_byte), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    #1 reset = 1'b0;

    // plain bytes
    send(9'h012); send(9'h034); do_flush();
    end_scenario("s1", 2, 64'h1234_0000_0000_0000);

    // carry through a 0xFF run
    send(9'h012); send(9'h0FF); send(9'h0FF); send(9'h105); do_flush();
    end_scenario("s2", 4, 64'h1300_0005_0000_0000);

    // run released by a plain word; empty group ignored; latency pinned
    send(9'h012); send(9'h0FF);
    send_group(4'd0, 9'h1AB, 9'h1CD, 1'b0);
    send(9'h040);
    check("lat_c1", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    check("lat_c2", 32'(bus.out_valid), 1);
    check("lat_byte", 32'(bus.out_byte), 32'h12);
    do_flush();
    end_scenario("s3", 3, 64'h12FF_4000_0000_0000);

    // two-word group; flush alongside a group is ignored
    send_group(4'd2, 9'h07F, 9'h180, 1'b0);
    send_group(4'd1, 9'h001, 9'h000, 1'b1);
    do_flush();
    end_scenario("s4", 3, 64'h8080_0100_0000_0000);

    // scenario 2 with a stalling sink
    ready_mode = 1;
    send(9'h012); send(9'h0FF); send(9'h0FF); send(9'h105); do_flush();
    end_scenario("s5", 4, 64'h1300_0005_0000_0000);
    ready_mode = 0;

    // carry with nothing pending: sticky error
    send(9'h101);
    repeat (2) @(negedge clk);
    check("err_set", 32'(bus.err), 1);
    send(9'h022); do_flush();
    end_scenario("s6", 2, 64'h0122_0000_0000_0000);
    check("err_sticky", 32'(bus.err), 1);

    // reset in the middle of a 3-byte run emission
    ready_mode = 1;
    send(9'h012); send(9'h0FF); send(9'h0FF); send(9'h0FF); send(9'h040);
    guard = 0;
    while (bus.dbg_state != S_EMIT_RUN && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_emit_run", 32'(bus.dbg_state), 32'(S_EMIT_RUN));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_err", 32'(bus.err), 0);
    check("mid_rst_out_byte", 32'(bus.out_byte), 0);
    exp_q.delete();
    hold.delete();
    got_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    ready_mode = 0;
    do_flush();
    end_scenario("s7", 0, 64'h0);

    repeat (3) @(negedge clk);
    check("final_done_count", 32'(done_seen), 32'(done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
